// File: rtl/rv32i_types.sv
// Shared types for the commit store buffer: drain FSM states and block-address helper.
package rv32i_types;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_REQ  = 2'd1,
        SB_WAIT = 2'd2
    } sb_state_e;

    // Aligned base address of the block containing addr (blk_bytes is a power of 2).
    function automatic logic [31:0] blk_base(input logic [31:0] addr, input int unsigned blk_bytes);
        return addr & ~(blk_bytes - 32'd1);
    endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Age-ordered byte merge for store-to-load forwarding; purely combinational.
// Entries are scanned oldest (head) to youngest so later matches overwrite earlier bytes.
module sb_fwd_merge
    import rv32i_types::*;
#(
    parameter int ENTRIES = 8,
    parameter int WORDS   = 2
) (
    input  logic [ENTRIES-1:0]               ent_vld_i,
    input  logic [ENTRIES-1:0][31:0]         ent_addr_i,
    input  logic [ENTRIES-1:0][4*WORDS-1:0]  ent_mask_i,
    input  logic [ENTRIES-1:0][32*WORDS-1:0] ent_data_i,
    input  logic [$clog2(ENTRIES)-1:0]       head_i,
    input  logic [31:0]                      fwd_addr_i,
    input  logic [3:0]                       fwd_rmask_i,
    output logic                             fwd_full_hit_o,
    output logic                             fwd_partial_o,
    output logic [31:0]                      fwd_data_o
);
    localparam int PW  = $clog2(ENTRIES);
    localparam int WSW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [PW-1:0]  idx;
    logic [WSW-1:0] wsel;
    logic [31:0]    blk;
    logic [3:0]     wmask, cov, hit;
    logic [31:0]    wdat, merged;

    always_comb begin
        wsel   = (WORDS > 1) ? fwd_addr_i[2 +: WSW] : '0;
        blk    = blk_base(fwd_addr_i, 4 * WORDS);
        idx    = '0;
        wmask  = '0;
        wdat   = '0;
        cov    = '0;
        merged = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            idx   = head_i + PW'(k);
            wmask = '0;
            wdat  = '0;
            for (int j = 0; j < WORDS; j++) begin
                if (WSW'(j) == wsel) begin
                    wmask = ent_mask_i[idx][4*j +: 4];
                    wdat  = ent_data_i[idx][32*j +: 32];
                end
            end
            if (ent_vld_i[idx] && (ent_addr_i[idx] == blk)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask[b]) begin
                        merged[8*b +: 8] = wdat[8*b +: 8];
                        cov[b]           = 1'b1;
                    end
                end
            end
        end
        hit            = cov & fwd_rmask_i;
        fwd_data_o     = merged;
        fwd_full_hit_o = (fwd_rmask_i != 4'd0) && (hit == fwd_rmask_i);
        fwd_partial_o  = (hit != 4'd0) && (hit != fwd_rmask_i);
    end

endmodule

// File: rtl/commit_store_buffer.sv
// Coalescing commit store buffer: circular FIFO of block entries drained to the D-cache.
// Drain starts on watermark, full, fence or idle timeout; the head entry is frozen while in flight.
module commit_store_buffer
    import rv32i_types::*;
#(
    parameter int ENTRIES      = 8,
    parameter int WORDS        = 2,
    parameter int HIGH_WM      = 6,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [31:0]                enq_addr,
    input  logic [3:0]                 enq_wmask,
    input  logic [31:0]                enq_wdata,
    output logic                       drain_valid,
    input  logic                       drain_ready,
    output logic [31:0]                drain_addr,
    output logic [4*WORDS-1:0]         drain_wmask,
    output logic [32*WORDS-1:0]        drain_wdata,
    input  logic                       drain_resp,
    input  logic [31:0]                fwd_addr,
    input  logic [3:0]                 fwd_rmask,
    output logic                       fwd_full_hit,
    output logic                       fwd_partial,
    output logic [31:0]                fwd_data,
    input  logic                       fence_req,
    output logic                       fence_ack,
    output logic [$clog2(ENTRIES):0]   count,
    output logic                       buf_empty,
    output logic                       buf_full
);
    localparam int PW  = $clog2(ENTRIES);
    localparam int CW  = PW + 1;
    localparam int MW  = 4 * WORDS;
    localparam int DW  = 32 * WORDS;
    localparam int TW  = $clog2(IDLE_TIMEOUT + 1);
    localparam int WSW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef struct packed {
        logic          vld;
        logic [31:0]   addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        ent_q [ENTRIES];
    entry_t        ent_d [ENTRIES];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, coal_idx;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    sb_state_e     state_q, state_d;

    logic [31:0]    enq_blk;
    logic [WSW-1:0] enq_wsel;
    logic [MW-1:0]  new_mask;
    logic [DW-1:0]  new_data;
    logic           in_flight, coal_hit, enq_fire, do_alloc, do_coal, pop, expired;

    logic [ENTRIES-1:0]          ent_vld;
    logic [ENTRIES-1:0][31:0]    ent_addr;
    logic [ENTRIES-1:0][MW-1:0]  ent_mask;
    logic [ENTRIES-1:0][DW-1:0]  ent_data;

    assign buf_empty   = (count_q == '0);
    assign buf_full    = (count_q == CW'(ENTRIES));
    assign count       = count_q;
    assign in_flight   = (state_q != SB_IDLE);
    assign expired     = (timer_q == TW'(IDLE_TIMEOUT));
    assign drain_valid = (state_q == SB_REQ);
    assign drain_addr  = ent_q[head_q].addr;
    assign drain_wmask = ent_q[head_q].mask;
    assign drain_wdata = ent_q[head_q].data;
    assign fence_ack   = fence_req && buf_empty && (state_q == SB_IDLE);

    // Place the incoming word into its slot of a block-wide mask/data pair.
    always_comb begin
        enq_blk  = blk_base(enq_addr, MW);
        enq_wsel = (WORDS > 1) ? enq_addr[2 +: WSW] : '0;
        new_mask = '0;
        new_data = '0;
        for (int j = 0; j < WORDS; j++) begin
            if (WSW'(j) == enq_wsel) begin
                new_mask[4*j +: 4]  = enq_wmask;
                new_data[32*j +: 32] = enq_wdata;
            end
        end
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_q[i].vld && (ent_q[i].addr == enq_blk) && !(in_flight && (PW'(i) == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = PW'(i);
            end
        end
        enq_ready = !fence_req && (!buf_full || coal_hit);
        enq_fire  = enq_valid && enq_ready;
        do_alloc  = enq_fire && !coal_hit;
        do_coal   = enq_fire && coal_hit;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            SB_IDLE: begin
                if (!buf_empty && ((count_q >= CW'(HIGH_WM)) || buf_full || fence_req || expired)) begin
                    state_d = SB_REQ;
                end
            end
            SB_REQ: begin
                if (drain_ready) begin
                    state_d = drain_resp ? SB_IDLE : SB_WAIT;
                    pop     = drain_resp;
                end
            end
            SB_WAIT: begin
                if (drain_resp) begin
                    state_d = SB_IDLE;
                    pop     = 1'b1;
                end
            end
            default: state_d = SB_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (do_coal && (coal_idx == PW'(i))) begin
                ent_d[i].mask = ent_q[i].mask | new_mask;
                for (int k = 0; k < MW; k++) begin
                    if (new_mask[k]) begin
                        ent_d[i].data[8*k +: 8] = new_data[8*k +: 8];
                    end
                end
            end
            if (do_alloc && (tail_q == PW'(i))) begin
                ent_d[i] = '{vld: 1'b1, addr: enq_blk, mask: new_mask, data: new_data};
            end
            if (pop && (head_q == PW'(i))) begin
                ent_d[i].vld = 1'b0;
            end
        end
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(do_alloc);
        count_d = count_q + CW'(do_alloc) - CW'(pop);
        if (enq_fire || buf_empty) begin
            timer_d = '0;
        end else if (!expired) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            timer_q <= '0;
            state_q <= SB_IDLE;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            timer_q <= timer_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ent_vld[i]  = ent_q[i].vld;
            ent_addr[i] = ent_q[i].addr;
            ent_mask[i] = ent_q[i].mask;
            ent_data[i] = ent_q[i].data;
        end
    end

    sb_fwd_merge #(
        .ENTRIES (ENTRIES),
        .WORDS   (WORDS)
    ) u_fwd (
        .ent_vld_i      (ent_vld),
        .ent_addr_i     (ent_addr),
        .ent_mask_i     (ent_mask),
        .ent_data_i     (ent_data),
        .head_i         (head_q),
        .fwd_addr_i     (fwd_addr),
        .fwd_rmask_i    (fwd_rmask),
        .fwd_full_hit_o (fwd_full_hit),
        .fwd_partial_o  (fwd_partial),
        .fwd_data_o     (fwd_data)
    );

endmodule

// File: tb/tb_commit_store_buffer.sv
// Bench for commit_store_buffer: directed scenarios then random traffic, every cycle checked
// against a queue-based reference of buffer contents and drain handshake rules.
module tb_commit_store_buffer;
    localparam int ENTRIES = 4, WORDS = 2, HIGH_WM = 3, IDLE_TIMEOUT = 8;

    logic        clk, rst_n;
    logic        enq_valid, enq_ready;
    logic [31:0] enq_addr, enq_wdata;
    logic [3:0]  enq_wmask;
    logic        drain_valid, drain_ready, drain_resp;
    logic [31:0] drain_addr;
    logic [7:0]  drain_wmask;
    logic [63:0] drain_wdata;
    logic [31:0] fwd_addr, fwd_data;
    logic [3:0]  fwd_rmask;
    logic        fwd_full_hit, fwd_partial, fence_req, fence_ack, buf_empty, buf_full;
    logic [2:0]  count;

    commit_store_buffer #(.ENTRIES(ENTRIES), .WORDS(WORDS), .HIGH_WM(HIGH_WM), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr), .enq_wmask(enq_wmask), .enq_wdata(enq_wdata),
        .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
        .drain_wmask(drain_wmask), .drain_wdata(drain_wdata), .drain_resp(drain_resp),
        .fwd_addr(fwd_addr), .fwd_rmask(fwd_rmask), .fwd_full_hit(fwd_full_hit), .fwd_partial(fwd_partial), .fwd_data(fwd_data),
        .fence_req(fence_req), .fence_ack(fence_ack), .count(count), .buf_empty(buf_empty), .buf_full(buf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] blk;
        logic [7:0]  mask;
        logic [63:0] data;
    } ment_t;

    ment_t mq[$];
    bit    m_busy, m_acc;
    int    m_timer;
    int    n_cmp, n_bad;
    bit          g_rdy, g_resp, g_fen;
    logic [31:0] g_fa;
    logic [3:0]  g_fm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int find_coal(input logic [31:0] a);
        int r = -1;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].blk == (a & ~32'h7) && !(i == 0 && m_busy)) r = i;
        return r;
    endfunction

    // One clock: drive at negedge, check combinational outputs, then advance the reference.
    task automatic cyc(input bit ev, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        int ci, presz, w;
        bit exp_rdy, fire, pop;
        logic [31:0] fd;
        logic [3:0]  cov, hit;
        logic [7:0]  nm, bm;
        logic [63:0] ndat;
        @(negedge clk);
        enq_valid = ev; enq_addr = a; enq_wmask = m; enq_wdata = d;
        drain_ready = g_rdy; drain_resp = g_resp; fence_req = g_fen;
        fwd_addr = g_fa; fwd_rmask = g_fm;
        #1;
        presz   = mq.size();
        ci      = find_coal(a);
        exp_rdy = !g_fen && (presz < ENTRIES || ci >= 0);
        chk("enq_ready", 64'(enq_ready), 64'(exp_rdy));
        chk("count", 64'(count), 64'(presz));
        chk("buf_empty", 64'(buf_empty), 64'(presz == 0));
        chk("buf_full", 64'(buf_full), 64'(presz == ENTRIES));
        chk("drain_valid", 64'(drain_valid), 64'(m_busy && !m_acc));
        if (m_busy && !m_acc) begin
            chk("drain_addr", 64'(drain_addr), 64'(mq[0].blk));
            chk("drain_wmask", 64'(drain_wmask), 64'(mq[0].mask));
            chk("drain_wdata", drain_wdata, mq[0].data);
        end
        chk("fence_ack", 64'(fence_ack), 64'(g_fen && presz == 0 && !m_busy));
        fd = '0; cov = '0; w = int'(g_fa[2]);
        for (int i = 0; i < presz; i++) begin
            if (mq[i].blk == (g_fa & ~32'h7)) begin
                for (int b = 0; b < 4; b++) begin
                    if (1'(mq[i].mask >> (4*w + b))) begin
                        fd  = (fd & ~(32'hFF << (8*b))) | (32'(8'(mq[i].data >> (32*w + 8*b))) << (8*b));
                        cov = cov | 4'(1 << b);
                    end
                end
            end
        end
        hit = cov & g_fm;
        chk("fwd_data", 64'(fwd_data), 64'(fd));
        chk("fwd_full_hit", 64'(fwd_full_hit), 64'(g_fm != 0 && hit == g_fm));
        chk("fwd_partial", 64'(fwd_partial), 64'(hit != 0 && hit != g_fm));
        // Reference update for the coming rising edge.
        fire = ev && exp_rdy;
        pop  = 1'b0;
        if (m_busy) begin
            if (!m_acc) begin
                if (g_rdy && g_resp) pop = 1'b1;
                else if (g_rdy) m_acc = 1'b1;
            end else if (g_resp) pop = 1'b1;
        end else if (presz > 0 && (presz >= HIGH_WM || presz == ENTRIES || g_fen || m_timer == IDLE_TIMEOUT)) begin
            m_busy = 1'b1;
        end
        if (fire || presz == 0) m_timer = 0;
        else if (m_timer < IDLE_TIMEOUT) m_timer++;
        if (fire) begin
            nm   = 8'(m) << (4*a[2]);
            ndat = 64'(d) << (32*a[2]);
            if (ci >= 0) begin
                bm = mq[ci].mask;
                for (int k = 0; k < 8; k++)
                    if (nm[k]) mq[ci].data = (mq[ci].data & ~(64'hFF << (8*k))) | (ndat & (64'hFF << (8*k)));
                mq[ci].mask = bm | nm;
            end else begin
                mq.push_back('{blk: a & ~32'h7, mask: nm, data: ndat});
            end
        end
        if (pop) begin
            void'(mq.pop_front());
            m_busy = 1'b0;
            m_acc  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic wait_dv(input string tag);
        for (int t = 0; t < 40 && !drain_valid; t++) idle(1);
        chk(tag, 64'(drain_valid), 64'd1);
    endtask

    task automatic drain_all();
        g_fen = 1'b1; g_rdy = 1'b1; g_resp = 1'b1;
        for (int t = 0; t < 100 && !fence_ack; t++) idle(1);
        chk("drain_all_ack", 64'(fence_ack), 64'd1);
        g_fen = 1'b0; g_rdy = 1'b0; g_resp = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        enq_valid = 1'b0; drain_ready = 1'b0; drain_resp = 1'b0; fence_req = 1'b1;
        fwd_addr = 32'h100; fwd_rmask = 4'hF;
        #1;
        chk("rst_enq_ready_fence", 64'(enq_ready), 64'd0);
        fence_req = 1'b0;
        #1;
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(buf_empty), 64'd1);
        chk("rst_full", 64'(buf_full), 64'd0);
        chk("rst_drain_valid", 64'(drain_valid), 64'd0);
        chk("rst_fwd_hit", 64'({fwd_full_hit, fwd_partial}), 64'd0);
        mq.delete(); m_busy = 1'b0; m_acc = 1'b0; m_timer = 0;
        g_rdy = 1'b0; g_resp = 1'b0; g_fen = 1'b0; g_fa = 32'h0; g_fm = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b1; enq_valid = 1'b0; enq_addr = '0; enq_wmask = '0; enq_wdata = '0;
        drain_ready = 1'b0; drain_resp = 1'b0; fwd_addr = '0; fwd_rmask = '0; fence_req = 1'b0;
        do_reset();

        // Two stores to one block coalesce; idle timeout drains the merged block.
        cyc(1'b1, 32'h100, 4'h3, 32'h0000_AAAA);
        cyc(1'b1, 32'h104, 4'hC, 32'hBBBB_0000);
        idle(1);
        chk("s1_count", 64'(count), 64'd1);
        wait_dv("s1_timeout_drain");
        chk("s1_drain_addr", 64'(drain_addr), 64'h100);
        chk("s1_drain_wmask", 64'(drain_wmask), 64'hC3);
        chk("s1_drain_wdata", drain_wdata, 64'hBBBB0000_0000AAAA);
        g_rdy = 1'b1; idle(1); g_rdy = 1'b0;
        g_resp = 1'b1; idle(1); g_resp = 1'b0;
        idle(1);
        chk("s1_count_after", 64'(count), 64'd0);

        // High watermark, split handshake, then wrap traffic.
        cyc(1'b1, 32'h000, 4'hF, 32'h1111_1111);
        cyc(1'b1, 32'h010, 4'hF, 32'h2222_2222);
        cyc(1'b1, 32'h020, 4'hF, 32'h3333_3333);
        wait_dv("s2_watermark_drain");
        chk("s2_head_addr", 64'(drain_addr), 64'h000);
        g_rdy = 1'b1; idle(1); g_rdy = 1'b0;
        idle(1);
        g_resp = 1'b1; idle(1); g_resp = 1'b0;
        idle(1);
        chk("s2_count_3to2", 64'(count), 64'd2);
        g_rdy = 1'b1; g_resp = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'h040 + 32'(8*i), 4'hF, $urandom);
        drain_all();

        // Full buffer: new block refused, non-head block still coalesces.
        cyc(1'b1, 32'h200, 4'h1, 32'h0000_00A0);
        cyc(1'b1, 32'h208, 4'h1, 32'h0000_00A1);
        cyc(1'b1, 32'h210, 4'h1, 32'h0000_00A2);
        cyc(1'b1, 32'h218, 4'h1, 32'h0000_00A3);
        idle(1);
        chk("s3_full", 64'(buf_full), 64'd1);
        cyc(1'b1, 32'h220, 4'hF, 32'hDEAD_BEEF);
        chk("s3_refuse_new", 64'(enq_ready), 64'd0);
        cyc(1'b1, 32'h20C, 4'hF, 32'hCAFE_F00D);
        chk("s3_accept_coalesce", 64'(enq_ready), 64'd1);
        idle(1);
        chk("s3_count_same", 64'(count), 64'd4);
        drain_all();

        // In-flight head is not merged into; forwarding returns the younger byte.
        cyc(1'b1, 32'h100, 4'h1, 32'h0000_0011);
        wait_dv("s4_head_in_flight");
        cyc(1'b1, 32'h100, 4'h1, 32'h0000_0022);
        g_fa = 32'h100; g_fm = 4'h1;
        idle(1);
        chk("s4_count_alloc", 64'(count), 64'd2);
        chk("s4_full_hit", 64'(fwd_full_hit), 64'd1);
        chk("s4_fwd_byte0", 64'(fwd_data[7:0]), 64'h22);
        g_fa = 32'h0; g_fm = 4'h0;
        drain_all();

        // Fence drains both entries back-to-back and blocks enqueue.
        cyc(1'b1, 32'h300, 4'hF, 32'h0300_0300);
        cyc(1'b1, 32'h308, 4'hF, 32'h0308_0308);
        g_fen = 1'b1; g_rdy = 1'b1; g_resp = 1'b1;
        cyc(1'b1, 32'h310, 4'hF, 32'h0310_0310);
        chk("s5_fence_blocks_enq", 64'(enq_ready), 64'd0);
        for (int t = 0; t < 20 && !fence_ack; t++) idle(1);
        chk("s5_fence_ack", 64'(fence_ack), 64'd1);
        chk("s5_empty", 64'(count), 64'd0);
        g_fen = 1'b0; g_rdy = 1'b0; g_resp = 1'b0;

        // Reset while waiting for write completion; late response is ignored.
        cyc(1'b1, 32'h400, 4'hF, 32'h0400_0400);
        wait_dv("s6_drain_start");
        g_rdy = 1'b1; idle(1); g_rdy = 1'b0;
        idle(1);
        do_reset();
        g_resp = 1'b1; idle(1); g_resp = 1'b0;
        idle(1);
        chk("s6_count_zero", 64'(count), 64'd0);
        chk("s6_drain_valid", 64'(drain_valid), 64'd0);

        // Random traffic against the reference.
        for (int i = 0; i < 1500; i++) begin
            g_rdy  = ($urandom_range(0, 1) == 1);
            g_resp = ($urandom_range(0, 2) == 0);
            g_fen  = ($urandom_range(0, 15) == 0);
            g_fa   = 32'h500 + 32'($urandom_range(0, 5) << 3) + 32'($urandom_range(0, 1) << 2);
            g_fm   = 4'($urandom);
            cyc($urandom_range(0, 1) == 1,
                32'h500 + 32'($urandom_range(0, 5) << 3) + 32'($urandom_range(0, 7)),
                4'($urandom), $urandom);
        end
        drain_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
